// File: rtl/qarctan_iter_if.sv
// Handshake bundle for the iterative quadrant arctangent block.
interface qarctan_iter_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] y;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  busy;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/qarctan_iter.sv
// Iterative quadrant arctangent: angle of (x, y) in Q(QUANT_BITS) using a
// first-order approximation around pi/4 or 3pi/4. The ratio is produced by
// a restoring divider, one quotient bit per cycle.
module qarctan_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int QUANT_BITS = 10,
    parameter int QUAD_ONE   = 804,
    parameter int QUAD_THREE = 2412
) (
    input logic          clk,
    input logic          reset,
    qarctan_iter_if.slave bus
);
    localparam int DW   = DATA_WIDTH;
    localparam int ITER = DATA_WIDTH + QUANT_BITS;
    localparam int W1   = DATA_WIDTH + 1;   // sum width, never overflows
    localparam int RW   = DATA_WIDTH + 2;   // remainder holds up to 2*den
    localparam int CW   = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, DIVIDE, SCALE, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [ITER-1:0] dvd;
    logic [RW-1:0]   rem;
    logic [DW-1:0]   quo;     // |r| <= 2^QUANT_BITS, so high quotient bits are always zero
    logic [W1-1:0]   den;     // unsigned; can reach 2^DW + 1
    logic signed [DW-1:0] base;
    logic            num_neg;
    logic            y_neg;
    logic [DW-1:0]   out_q;

    logic accept;
    assign accept = bus.in_valid && (state == IDLE);

    // Operand preparation from the live inputs, captured only on acceptance
    logic signed [W1-1:0] x_e, y_e, ay, num;
    logic [W1-1:0]        den_in, num_mag;
    assign x_e     = $signed({bus.x[DW-1], bus.x});
    assign y_e     = $signed({bus.y[DW-1], bus.y});
    assign ay      = (y_e[W1-1] ? -y_e : y_e) + W1'(1);
    assign num     = x_e[W1-1] ? (x_e + ay) : (x_e - ay);
    assign den_in  = x_e[W1-1] ? W1'(ay - x_e) : W1'(x_e + ay);
    assign num_mag = num[W1-1] ? W1'(-num) : W1'(num);

    // One restoring-divide step
    logic [RW-1:0] trial;
    logic          ge;
    assign trial = {rem[RW-2:0], dvd[ITER-1]};
    assign ge    = trial >= {1'b0, den};

    // Linear correction around the quadrant base angle
    logic signed [DW-1:0]   r, scaled, angle, res;
    logic signed [2*DW-1:0] r_ext, q1_ext;
    assign r      = num_neg ? -$signed(quo) : $signed(quo);
    assign r_ext  = {{DW{r[DW-1]}}, r};
    assign q1_ext = $signed((2*DW)'(QUAD_ONE));
    assign scaled = DW'((q1_ext * r_ext) >>> QUANT_BITS);
    assign angle  = base - scaled;
    assign res    = y_neg ? -angle : angle;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = DIVIDE;
            DIVIDE:  if (cnt == CW'(ITER - 1)) state_nx = SCALE;
            SCALE:   state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, divider iteration, final scaling
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            dvd     <= '0;
            rem     <= '0;
            quo     <= '0;
            den     <= '0;
            base    <= '0;
            num_neg <= 1'b0;
            y_neg   <= 1'b0;
            out_q   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt     <= '0;
                    dvd     <= ITER'({num_mag, {QUANT_BITS{1'b0}}});
                    rem     <= '0;
                    quo     <= '0;
                    den     <= den_in;
                    base    <= x_e[W1-1] ? DW'(QUAD_THREE) : DW'(QUAD_ONE);
                    num_neg <= num[W1-1];
                    y_neg   <= bus.y[DW-1];
                end
                DIVIDE: begin
                    cnt <= cnt + CW'(1);
                    dvd <= {dvd[ITER-2:0], 1'b0};
                    rem <= ge ? (trial - {1'b0, den}) : trial;
                    quo <= {quo[DW-2:0], ge};
                end
                SCALE:   out_q <= res;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_q;
endmodule

// File: tb/tb_qarctan_iter.sv
// Directed bench for qarctan_iter: expected angles are pushed on issue and a
// monitor pops and compares on every output handshake.
module tb_qarctan_iter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    qarctan_iter_if #(.DATA_WIDTH(32)) bus ();
    qarctan_iter dut (.clk(clk), .reset(reset), .bus(bus));

    int     checks = 0;
    int     errors = 0;
    longint exp_q[$];

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: one comparison per accepted result
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d expected none", $signed(bus.out_data));
            end else begin
                chk("result", $signed(bus.out_data), exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] xv, input logic [31:0] yv,
                        input bit push, input longint e);
        @(negedge clk);
        chk("accept_ready", {63'd0, bus.in_ready}, 64'sd1);
        bus.in_valid = 1'b1;
        bus.x = xv;
        bus.y = yv;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Edges after the accepting edge until out_valid becomes visible
    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.out_valid === 1'b1) break;
        end
        if (bus.out_valid !== 1'b1) chk("out_timeout", {63'd0, bus.out_valid}, 64'sd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && bus.in_ready === 1'b1) break;
            @(posedge clk);
            #1;
        end
        chk("drain", exp_q.size(), 64'sd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        reset        = 1'b1;
        bus.in_valid = 1'b1;   // handshake offered during reset must be ignored
        bus.x        = 32'd1024;
        bus.y        = 32'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {63'd0, bus.in_ready},  64'sd1);
        chk("rst_busy",      {63'd0, bus.busy},      64'sd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'sd0);
        chk("rst_out_data",  $signed(bus.out_data),  64'sd0);
        bus.in_valid = 1'b0;
        reset = 1'b0;

        // x=1024, y=0 with the first result visible after edge 43 (sampled on edge 44)
        send(32'd1024, 32'd0, 1, 2);
        wait_out(lat);
        chk("latency", lat + 1, 64'sd44);
        wait_idle();

        send(32'd0, 32'd1024, 1, 1608);           wait_out(lat); wait_idle();
        send(32'd0, -32'sd1024, 1, -1608);        wait_out(lat); wait_idle();
        send(-32'sd1024, 32'd0, 1, 3215);         wait_out(lat); wait_idle();
        send(32'd1024, 32'd1024, 1, 804);         wait_out(lat); wait_idle();

        // Back-pressure: result must hold while out_ready is low
        bus.out_ready = 1'b0;
        send(32'd0, 32'd1024, 1, 1608);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("stall_data",     $signed(bus.out_data),  64'sd1608);
            chk("stall_in_ready", {63'd0, bus.in_ready},  64'sd0);
            chk("stall_valid",    {63'd0, bus.out_valid}, 64'sd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", {63'd0, bus.in_ready}, 64'sd1);
        chk("release_busy",     {63'd0, bus.busy},     64'sd0);
        wait_idle();

        // Reset in the middle of the divide discards the operation
        send(32'd1024, 32'd0, 0, 0);
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("midrst_in_ready",  {63'd0, bus.in_ready},  64'sd1);
        chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'sd0);
        seen = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen++;
        end
        chk("midrst_no_pulse", seen, 64'sd0);
        send(32'd1024, 32'd0, 1, 2);
        wait_out(lat);
        wait_idle();

        // in_valid held with changing operands while busy: only the first pair counts
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x = 32'd1024;
        bus.y = 32'd0;
        exp_q.push_back(2);
        @(posedge clk);
        #1;
        lat = 0;
        while (lat < 200 && bus.out_valid !== 1'b1) begin
            bus.x = $urandom();
            bus.y = $urandom();
            @(posedge clk);
            #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("hold_completed", {63'd0, bus.out_valid}, 64'sd1);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("hold_single", {63'd0, bus.busy}, 64'sd0);

        // Most-negative corner: den = 2^32 + 1, ratio truncates to zero
        send(32'h8000_0000, 32'h8000_0000, 1, -2412);
        wait_out(lat);
        chk("extreme_valid", {63'd0, bus.out_valid}, 64'sd1);
        wait_idle();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
